// File: rtl/ballot_front_end_if.sv
// Signal bundle between the ballot front end and its environment: raw buttons,
// officer/counter handshakes in, vote lines and status out.
interface ballot_front_end_if;
  logic       btn_a;
  logic       btn_b;
  logic       btn_c;
  logic       ballot_issue;
  logic       voting_enabled;
  logic       busy;
  logic       vote_a;
  logic       vote_b;
  logic       vote_c;
  logic       ballot_ready;
  logic       invalid_press;
  logic       ack_timeout;
  logic [7:0] ballots_cast;

  modport master (
    output btn_a, btn_b, btn_c, ballot_issue, voting_enabled, busy,
    input  vote_a, vote_b, vote_c, ballot_ready, invalid_press, ack_timeout, ballots_cast
  );

  modport slave (
    input  btn_a, btn_b, btn_c, ballot_issue, voting_enabled, busy,
    output vote_a, vote_b, vote_c, ballot_ready, invalid_press, ack_timeout, ballots_cast
  );
endinterface

// File: rtl/ballot_front_end.sv
// Voting-booth front end: synchronises and debounces three candidate buttons and
// presents exactly one vote per officer-issued ballot to the downstream counter.
module ballot_front_end #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic              clk,
  input  logic              reset,
  ballot_front_end_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  function automatic logic [1:0] count_ones(input logic [2:0] v);
    count_ones = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  logic [2:0] btn_s;
  logic [2:0] rise_s;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] deb_r;
  logic [2:0] deb_prev_r;
  logic [7:0] db_cnt_r [3];

  state_t     state_r;
  logic [2:0] vote_r;
  logic       ballot_ready_r;
  logic       invalid_press_r;
  logic       ack_timeout_r;
  logic [7:0] ballots_cast_r;
  logic [7:0] ack_tmr_r;

  assign btn_s  = {bus.btn_c, bus.btn_b, bus.btn_a};
  assign rise_s = deb_r & ~deb_prev_r;

  // Two-flop synchronisers followed by per-button consecutive-mismatch debouncers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 3'b000;
      sync2_r    <= 3'b000;
      deb_r      <= 3'b000;
      deb_prev_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= 8'd0;
      end
    end else begin
      sync1_r    <= btn_s;
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            deb_r[i]    <= sync2_r[i];
            db_cnt_r[i] <= 8'd0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 8'd1;
          end
        end else begin
          db_cnt_r[i] <= 8'd0;
        end
      end
    end
  end

  // Ballot state machine; every output is a register updated here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      vote_r          <= 3'b000;
      ballot_ready_r  <= 1'b0;
      invalid_press_r <= 1'b0;
      ack_timeout_r   <= 1'b0;
      ballots_cast_r  <= 8'd0;
      ack_tmr_r       <= 8'd0;
    end else begin
      invalid_press_r <= 1'b0;
      ack_timeout_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          vote_r <= 3'b000;
          if (bus.ballot_issue && bus.voting_enabled) begin
            ballot_ready_r <= 1'b1;
            state_r        <= ARMED;
          end else begin
            state_r <= IDLE;
          end
        end
        ARMED: begin
          vote_r <= 3'b000;
          if (!bus.voting_enabled) begin
            ballot_ready_r <= 1'b0;
            state_r        <= IDLE;
          end else if (rise_s != 3'b000) begin
            // A press only counts when exactly one button is down at that moment
            if (count_ones(deb_r) == 2'd1) begin
              vote_r    <= deb_r;
              ack_tmr_r <= 8'd0;
              state_r   <= PRESENT;
            end else begin
              invalid_press_r <= 1'b1;
              state_r         <= RELEASE;
            end
          end else begin
            state_r <= ARMED;
          end
        end
        PRESENT: begin
          if (bus.busy) begin
            vote_r         <= 3'b000;
            ballot_ready_r <= 1'b0;
            state_r        <= RELEASE;
            if (ballots_cast_r != 8'hFF) begin
              ballots_cast_r <= ballots_cast_r + 8'd1;
            end else begin
              ballots_cast_r <= ballots_cast_r;
            end
          end else if (!bus.voting_enabled) begin
            vote_r         <= 3'b000;
            ballot_ready_r <= 1'b0;
            state_r        <= RELEASE;
          end else if (ack_tmr_r == ACK_LAST) begin
            vote_r        <= 3'b000;
            ack_timeout_r <= 1'b1;
            state_r       <= RELEASE;
          end else begin
            ack_tmr_r <= ack_tmr_r + 8'd1;
            state_r   <= PRESENT;
          end
        end
        RELEASE: begin
          vote_r <= 3'b000;
          if (deb_r == 3'b000) begin
            if (ballot_ready_r && bus.voting_enabled) begin
              state_r <= ARMED;
            end else begin
              ballot_ready_r <= 1'b0;
              state_r        <= IDLE;
            end
          end else begin
            state_r <= RELEASE;
          end
        end
        default: begin
          vote_r         <= 3'b000;
          ballot_ready_r <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign bus.vote_a        = vote_r[0];
  assign bus.vote_b        = vote_r[1];
  assign bus.vote_c        = vote_r[2];
  assign bus.ballot_ready  = ballot_ready_r;
  assign bus.invalid_press = invalid_press_r;
  assign bus.ack_timeout   = ack_timeout_r;
  assign bus.ballots_cast  = ballots_cast_r;

endmodule

// File: tb/tb_ballot_front_end.sv
// Scoreboard bench for ballot_front_end: expected vote/invalid/timeout events are
// queued as stimulus is applied and matched by a monitor as the DUT emits them.
module tb_ballot_front_end;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   errors   = 0;
  int   exp_cast = 0;
  int   exp_q[$];
  logic [2:0] mon_prev = 3'b000;
  logic [2:0] mon_cur;
  int   mon_exp;

  ballot_front_end_if bus();

  ballot_front_end #(.DEBOUNCE_CYCLES(16), .ACK_TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Event codes: 1/2/4 vote a/b/c started, 8 invalid_press, 16 ack_timeout
  always @(negedge clk) begin
    mon_cur = {bus.vote_c, bus.vote_b, bus.vote_a};
    if (!reset) begin
      checks++;
      if ($countones(mon_cur) > 1) begin
        errors++;
        $display("FAIL onehot: votes=%b, at most one may be high", mon_cur);
      end
      if (mon_cur != 3'b000 && mon_prev == 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL vote_event: unexpected vote %b, none expected", mon_cur);
        end else begin
          mon_exp = exp_q.pop_front();
          if (int'(mon_cur) !== mon_exp) begin
            errors++;
            $display("FAIL vote_event: got code %0d expected %0d", int'(mon_cur), mon_exp);
          end
        end
      end
      if (bus.invalid_press || bus.ack_timeout) begin
        checks++;
        mon_exp = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        if ((bus.invalid_press ? 8 : 16) !== mon_exp) begin
          errors++;
          $display("FAIL pulse_event: got code %0d expected %0d", bus.invalid_press ? 8 : 16, mon_exp);
        end
      end
    end
    mon_prev = mon_cur;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic issue_ballot();
    bus.ballot_issue = 1'b1;
    @(negedge clk);
    bus.ballot_issue = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {bus.btn_a, bus.btn_b, bus.btn_c} = 3'b000;
    bus.ballot_issue = 1'b0;
    bus.voting_enabled = 1'b0;
    bus.busy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.vote_a, bus.vote_b, bus.vote_c, bus.ballot_ready, bus.invalid_press, bus.ack_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.vote_a, bus.vote_b, bus.vote_c, bus.ballot_ready, bus.invalid_press, bus.ack_timeout});
    end
    checks++;
    if (bus.ballots_cast !== 8'd0) begin
      errors++;
      $display("FAIL reset_cast: got %0d expected 0", bus.ballots_cast);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ballot_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b expected 0", bus.ballot_ready);
    end
  endtask

  task automatic test_single_vote();
    int first = 0;
    int vb = 0;
    int oth = 0;
    bus.voting_enabled = 1'b1;
    issue_ballot();
    checks++;
    if (bus.ballot_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: got %b expected 1", bus.ballot_ready);
    end
    exp_q.push_back(2);
    bus.btn_b = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.vote_b) begin
        vb++;
        if (first == 0) first = n;
      end
      if (bus.vote_a || bus.vote_c) oth++;
      bus.busy = (bus.vote_b && vb == 3);
    end
    bus.btn_b = 1'b0;
    bus.busy = 1'b0;
    exp_cast++;
    repeat (24) @(negedge clk);
    checks++;
    if (first !== 19) begin
      errors++;
      $display("FAIL press_latency: got %0d cycles expected 19", first);
    end
    checks++;
    if (vb !== 3) begin
      errors++;
      $display("FAIL vote_b_cycles: got %0d expected 3", vb);
    end
    checks++;
    if (oth !== 0) begin
      errors++;
      $display("FAIL other_votes: got %0d expected 0", oth);
    end
    checks++;
    if (bus.ballots_cast !== 8'(exp_cast)) begin
      errors++;
      $display("FAIL cast_after_ack: got %0d expected %0d", bus.ballots_cast, exp_cast);
    end
    checks++;
    if (bus.ballot_ready !== 1'b0) begin
      errors++;
      $display("FAIL consumed_ready: got %b expected 0", bus.ballot_ready);
    end
  endtask

  task automatic test_glitch();
    int vc = 0;
    issue_ballot();
    bus.btn_a = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_a = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.vote_a || bus.vote_b || bus.vote_c) vc++;
    end
    checks++;
    if (vc !== 0) begin
      errors++;
      $display("FAIL glitch_votes: got %0d expected 0", vc);
    end
    checks++;
    if (bus.ballot_ready !== 1'b1) begin
      errors++;
      $display("FAIL glitch_ready: got %b expected 1", bus.ballot_ready);
    end
  endtask

  task automatic test_invalid();
    int inv = 0;
    int got = 0;
    exp_q.push_back(8);
    bus.btn_a = 1'b1;
    bus.btn_c = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.invalid_press) inv++;
    end
    bus.btn_a = 1'b0;
    bus.btn_c = 1'b0;
    repeat (24) @(negedge clk);
    checks++;
    if (inv !== 1) begin
      errors++;
      $display("FAIL invalid_pulses: got %0d expected 1", inv);
    end
    checks++;
    if (bus.ballot_ready !== 1'b1) begin
      errors++;
      $display("FAIL invalid_ready: got %b expected 1", bus.ballot_ready);
    end
    exp_q.push_back(4);
    bus.btn_c = 1'b1;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      @(negedge clk);
      if (bus.vote_c) got = 1;
    end
    bus.busy = 1'b1;
    @(negedge clk);
    bus.busy = 1'b0;
    exp_cast++;
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL retry_vote_c: got %0d expected 1", got);
    end
    checks++;
    if (bus.ballots_cast !== 8'(exp_cast)) begin
      errors++;
      $display("FAIL retry_cast: got %0d expected %0d", bus.ballots_cast, exp_cast);
    end
    bus.btn_c = 1'b0;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_timeout();
    int va = 0;
    int to = 0;
    issue_ballot();
    exp_q.push_back(1);
    exp_q.push_back(16);
    bus.btn_a = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.vote_a) va++;
      if (bus.ack_timeout) to++;
    end
    bus.btn_a = 1'b0;
    repeat (24) @(negedge clk);
    checks++;
    if (va !== 8) begin
      errors++;
      $display("FAIL timeout_vote_cycles: got %0d expected 8", va);
    end
    checks++;
    if (to !== 1) begin
      errors++;
      $display("FAIL timeout_pulses: got %0d expected 1", to);
    end
    checks++;
    if (bus.ballot_ready !== 1'b1 || bus.ballots_cast !== 8'(exp_cast)) begin
      errors++;
      $display("FAIL timeout_retained: got ready=%b cast=%0d expected ready=1 cast=%0d",
               bus.ballot_ready, bus.ballots_cast, exp_cast);
    end
    bus.voting_enabled = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ballot_ready !== 1'b0) begin
      errors++;
      $display("FAIL revoke_ready: got %b expected 0", bus.ballot_ready);
    end
    issue_ballot();
    checks++;
    if (bus.ballot_ready !== 1'b0) begin
      errors++;
      $display("FAIL disabled_issue: got %b expected 0", bus.ballot_ready);
    end
    bus.voting_enabled = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] msk;
    int got;
    for (int k = 0; k < 256; k++) begin
      msk = 3'(1 << (k % 3));
      issue_ballot();
      exp_q.push_back(int'(msk));
      {bus.btn_c, bus.btn_b, bus.btn_a} = msk;
      got = 0;
      for (int n = 1; n <= 40 && got == 0; n++) begin
        @(negedge clk);
        if (bus.vote_a || bus.vote_b || bus.vote_c) got = 1;
      end
      bus.ballot_issue = 1'b1;
      @(negedge clk);
      bus.ballot_issue = 1'b0;
      bus.busy = 1'b1;
      @(negedge clk);
      bus.busy = 1'b0;
      exp_cast++;
      {bus.btn_c, bus.btn_b, bus.btn_a} = 3'b000;
      repeat (22) @(negedge clk);
      checks++;
      if (bus.ballot_ready !== 1'b0) begin
        errors++;
        $display("FAIL stacked_ballot[%0d]: got ready=%b expected 0", k, bus.ballot_ready);
      end
      checks++;
      if (bus.ballots_cast !== 8'((exp_cast > 255) ? 255 : exp_cast)) begin
        errors++;
        $display("FAIL cast_count[%0d]: got %0d expected %0d", k, bus.ballots_cast,
                 (exp_cast > 255) ? 255 : exp_cast);
      end
    end
    checks++;
    if (bus.ballots_cast !== 8'd255) begin
      errors++;
      $display("FAIL cast_saturate: got %0d expected 255", bus.ballots_cast);
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    issue_ballot();
    exp_q.push_back(1);
    bus.btn_a = 1'b1;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      @(negedge clk);
      if (bus.vote_a) got = 1;
    end
    #1 reset = 1'b1;
    #1;
    exp_cast = 0;
    checks++;
    if (bus.vote_a !== 1'b0 || bus.ballots_cast !== 8'd0 || bus.ballot_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got vote_a=%b cast=%0d ready=%b expected 0/0/0",
               bus.vote_a, bus.ballots_cast, bus.ballot_ready);
    end
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL pre_reset_vote: got %0d expected 1", got);
    end
    repeat (2) @(negedge clk);
    bus.btn_a = 1'b0;
    reset = 1'b0;
    repeat (24) @(negedge clk);
    checks++;
    if ({bus.vote_a, bus.ballot_ready} !== 2'b00 || bus.ballots_cast !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got vote_a=%b ready=%b cast=%0d expected 0/0/0",
               bus.vote_a, bus.ballot_ready, bus.ballots_cast);
    end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_glitch();
    test_invalid();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
